// File: rtl/vending_pkg.sv
// Shared vending definitions: coin values, balance width and the change
// dispenser state encoding.
package vending_pkg;

  localparam int MONEY_WIDTH   = 12;
  localparam int POUND_VALUE   = 100;
  localparam int PENCE20_VALUE = 20;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    FIRE,
    SENSE,
    GAP,
    FINISH
  } state_t;

  typedef enum logic {
    COIN_POUND,
    COIN_PENCE20
  } coin_t;

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter. expired is high in the last cycle of a loaded
// duration, so a load of N gives N cycles including the expiry cycle.
module pulse_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] load,
  output logic         expired
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (start) begin
      count <= load;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // A zero load behaves like a load of one rather than never expiring.
  assign expired = (count <= W'(1));

endmodule

// File: rtl/change_dispenser.sv
// Pays out a captured refund balance as pound and 20p coins, one confirmed
// drop at a time, while tracking hopper stock and per-hopper jams.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int MONEY_W        = MONEY_WIDTH,
  parameter int CNT_W          = 6,
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int GAP_CYCLES     = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               refund,
  input  logic [MONEY_W-1:0] money,
  output logic               refund_ack,
  input  logic               coin_sense,
  input  logic               load_pound,
  input  logic               load_pence20,
  output logic               pound_out,
  output logic               pence20_out,
  output logic [CNT_W-1:0]   pound_count,
  output logic [CNT_W-1:0]   pence20_count,
  output logic               busy,
  output logic               done,
  output logic               short_change,
  output logic [MONEY_W-1:0] residual,
  output logic               jam_pound,
  output logic               jam_pence20
);

  localparam int TMR_MAX_A = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_MAX   = (TMR_MAX_A > GAP_CYCLES) ? TMR_MAX_A : GAP_CYCLES;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] PULSE_LD   = TMR_W'(PULSE_CYCLES);
  localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] GAP_LD     = TMR_W'(GAP_CYCLES);

  state_t             state;
  coin_t              coin_sel;
  logic [MONEY_W-1:0] remaining;
  logic [MONEY_W-1:0] coin_value;
  logic               sensed;

  logic               pick_pound;
  logic               pick_pence20;
  logic               drop;
  logic               timeout;
  logic               dec_pound;
  logic               dec_pence20;

  logic               tmr_start;
  logic [TMR_W-1:0]   tmr_load;
  logic               tmr_expired;

  // Saturating increment on load; a simultaneous load and drop cancel out.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] c,
                                                  input logic inc,
                                                  input logic dec);
    if (inc && !dec) return (c == '1) ? c : c + 1'b1;
    if (dec && !inc) return c - 1'b1;
    return c;
  endfunction

  assign pick_pound   = (remaining >= MONEY_W'(POUND_VALUE)) && (pound_count != '0) && !jam_pound;
  assign pick_pence20 = (remaining >= MONEY_W'(PENCE20_VALUE)) && (pence20_count != '0) && !jam_pence20;
  assign coin_value   = (coin_sel == COIN_POUND) ? MONEY_W'(POUND_VALUE) : MONEY_W'(PENCE20_VALUE);

  // A drop seen while the solenoid is still firing counts once, not again in SENSE.
  assign drop        = coin_sense && (((state == FIRE) && !sensed) || (state == SENSE));
  assign timeout     = (state == SENSE) && !coin_sense && tmr_expired;
  assign dec_pound   = drop && (coin_sel == COIN_POUND);
  assign dec_pence20 = drop && (coin_sel == COIN_PENCE20);

  // NOTE: every signal driven here gets a default first so no path through
  // the case leaves it unassigned, which would infer a latch.
  always_comb begin
    tmr_start = 1'b0;
    tmr_load  = '0;
    case (state)
      SELECT: begin
        tmr_start = pick_pound || pick_pence20;
        tmr_load  = PULSE_LD;
      end
      FIRE: begin
        tmr_start = tmr_expired;
        tmr_load  = (sensed || coin_sense) ? GAP_LD : TIMEOUT_LD;
      end
      SENSE: begin
        tmr_start = coin_sense;
        tmr_load  = GAP_LD;
      end
      default: ;
    endcase
  end

  pulse_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (tmr_start),
    .load   (tmr_load),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pound_count   <= '0;
      pence20_count <= '0;
      jam_pound     <= 1'b0;
      jam_pence20   <= 1'b0;
    end else begin
      pound_count   <= next_count(pound_count, load_pound, dec_pound);
      pence20_count <= next_count(pence20_count, load_pence20, dec_pence20);
      // A fresh timeout outranks a load landing in the same cycle.
      if (timeout && (coin_sel == COIN_POUND)) jam_pound <= 1'b1;
      else if (load_pound)                     jam_pound <= 1'b0;
      if (timeout && (coin_sel == COIN_PENCE20)) jam_pence20 <= 1'b1;
      else if (load_pence20)                     jam_pence20 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      coin_sel     <= COIN_POUND;
      remaining    <= '0;
      sensed       <= 1'b0;
      refund_ack   <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      pound_out    <= 1'b0;
      pence20_out  <= 1'b0;
      short_change <= 1'b0;
      residual     <= '0;
    end else begin
      refund_ack <= 1'b0;
      done       <= 1'b0;
      if (drop) begin
        remaining <= remaining - coin_value;
        sensed    <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (refund) begin
            remaining    <= money;
            short_change <= 1'b0;
            residual     <= '0;
            refund_ack   <= 1'b1;
            busy         <= 1'b1;
            state        <= SELECT;
          end
        end
        SELECT: begin
          sensed <= 1'b0;
          if (pick_pound) begin
            coin_sel  <= COIN_POUND;
            pound_out <= 1'b1;
            state     <= FIRE;
          end else if (pick_pence20) begin
            coin_sel    <= COIN_PENCE20;
            pence20_out <= 1'b1;
            state       <= FIRE;
          end else begin
            done         <= 1'b1;
            residual     <= remaining;
            short_change <= (remaining != '0);
            state        <= FINISH;
          end
        end
        FIRE: begin
          if (tmr_expired) begin
            pound_out   <= 1'b0;
            pence20_out <= 1'b0;
            state       <= (sensed || coin_sense) ? GAP : SENSE;
          end
        end
        SENSE: begin
          if (coin_sense)       state <= GAP;
          else if (tmr_expired) state <= SELECT;
        end
        GAP: begin
          if (tmr_expired) state <= SELECT;
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a reference payout model queues the
// expected pulses and payout results, and a monitor retires them.
module tb_change_dispenser;

  localparam int PULSE   = 4;
  localparam int MAXC    = 63;
  localparam int GAP_OK  = 5;   // pulse fall to next rise after a confirmed drop
  localparam int GAP_JAM = 17;  // pulse fall to next rise after a sense timeout

  typedef struct {
    bit pound;
    bit jam;
  } pulse_exp_t;

  typedef struct {
    int res;
    bit sc;
  } done_exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        refund = 1'b0;
  logic [11:0] money = '0;
  logic        coin_sense = 1'b0;
  logic        load_pound = 1'b0;
  logic        load_p20_drv = 1'b0;
  logic        sense_load = 1'b0;
  logic        refund_ack, pound_out, pence20_out, busy, done, short_change;
  logic        jam_pound, jam_pence20;
  logic [5:0]  pound_count, pence20_count;
  logic [11:0] residual;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pulse_exp_t exp_q[$];
  done_exp_t  done_q[$];

  // reference model state
  int mp = 0, mq = 0;
  bit mjp = 0, mjq = 0;
  bit pound_sense_en = 1;
  bit load_on_sense = 0;

  // monitor state
  bit was_on = 0, cur_pound = 0, both_seen = 0, have_prev = 0, prev_jam = 0, sense_p20 = 0;
  int on_len = 0, prev_fall = 0, sense_cnt = 0;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .refund       (refund),
    .money        (money),
    .refund_ack   (refund_ack),
    .coin_sense   (coin_sense),
    .load_pound   (load_pound),
    .load_pence20 (load_p20_drv | sense_load),
    .pound_out    (pound_out),
    .pence20_out  (pence20_out),
    .pound_count  (pound_count),
    .pence20_count(pence20_count),
    .busy         (busy),
    .done         (done),
    .short_change (short_change),
    .residual     (residual),
    .jam_pound    (jam_pound),
    .jam_pence20  (jam_pence20)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference payout: greedy pound then 20p, honouring stock and jams.
  task automatic model_payout(input int m);
    int rem;
    rem = m;
    forever begin
      if (rem >= 100 && mp > 0 && !mjp) begin
        exp_q.push_back('{pound: 1'b1, jam: !pound_sense_en});
        if (pound_sense_en) begin
          rem -= 100;
          mp--;
        end else begin
          mjp = 1;
        end
      end else if (rem >= 20 && mq > 0 && !mjq) begin
        exp_q.push_back('{pound: 1'b0, jam: 1'b0});
        rem -= 20;
        if (!load_on_sense) mq--;
      end else begin
        break;
      end
    end
    done_q.push_back('{res: rem, sc: (rem != 0)});
  endtask

  // Monitor and coin-sensor responder, sampling on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      was_on = 0; have_prev = 0; both_seen = 0; on_len = 0; sense_cnt = 0;
      coin_sense = 0; sense_load = 0;
    end else begin
      coin_sense = 0;
      sense_load = 0;
      if (sense_cnt != 0) begin
        sense_cnt--;
        if (sense_cnt == 0) begin
          coin_sense = 1;
          sense_load = load_on_sense && sense_p20;
        end
      end
      if ((pound_out || pence20_out) && !was_on) begin
        on_len = 0;
        both_seen = 0;
        if (have_prev) check("pulse_gap", cyc - prev_fall, prev_jam ? GAP_JAM : GAP_OK);
      end
      if (pound_out || pence20_out) begin
        on_len++;
        cur_pound = pound_out;
        if (pound_out && pence20_out) both_seen = 1;
      end
      if (!(pound_out || pence20_out) && was_on) begin
        check("both_solenoids", both_seen, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          pulse_exp_t e;
          e = exp_q.pop_front();
          check("pulse_denom_pound", cur_pound, e.pound);
          check("pulse_len", on_len, PULSE);
          prev_jam = e.jam;
        end
        prev_fall = cyc;
        have_prev = 1;
        sense_p20 = !cur_pound;
        if (!cur_pound || pound_sense_en) sense_cnt = 1;
      end
      if (done) begin
        check("busy_with_done", busy, 1);
        if (done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          done_exp_t d;
          d = done_q.pop_front();
          check("residual", residual, d.res);
          check("short_change", short_change, d.sc);
        end
        have_prev = 0;
      end
      was_on = pound_out || pence20_out;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_pound_out"}, pound_out, 0);
    check({tag, "_pence20_out"}, pence20_out, 0);
    check({tag, "_ack"}, refund_ack, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_short"}, short_change, 0);
    check({tag, "_residual"}, residual, 0);
    check({tag, "_jam_pound"}, jam_pound, 0);
    check({tag, "_jam_p20"}, jam_pence20, 0);
    check({tag, "_pound_cnt"}, pound_count, 0);
    check({tag, "_p20_cnt"}, pence20_count, 0);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pound_cnt"}, pound_count, mp);
    check({tag, "_p20_cnt"}, pence20_count, mq);
    check({tag, "_jam_pound"}, jam_pound, mjp);
    check({tag, "_jam_p20"}, jam_pence20, mjq);
  endtask

  task automatic load_pounds(input int n);
    if (n == 0) return;
    @(negedge clk) load_pound = 1;
    repeat (n - 1) @(negedge clk);
    @(negedge clk) load_pound = 0;
    mp = (mp + n > MAXC) ? MAXC : mp + n;
    mjp = 0;
  endtask

  task automatic load_p20(input int n);
    if (n == 0) return;
    @(negedge clk) load_p20_drv = 1;
    repeat (n - 1) @(negedge clk);
    @(negedge clk) load_p20_drv = 0;
    mq = (mq + n > MAXC) ? MAXC : mq + n;
    mjq = 0;
  endtask

  // Drives refund for one edge; returns at the falling edge of the ack cycle.
  task automatic issue(input int m);
    @(negedge clk);
    refund = 1;
    money = 12'(m);
    model_payout(m);
    @(negedge clk);
    refund = 0;
    check("refund_ack", refund_ack, 1);
    check("busy_after_refund", busy, 1);
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      check("done_timeout", 0, 1);
    end else begin
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1;

    // 140p from 3 pounds / 5 twenties: one pound, two 20p
    load_pounds(3);
    load_p20(5);
    check_model("loaded");
    issue(140);
    @(negedge clk);
    check("first_pulse_latency", pound_out, 1);
    wait_done(n);
    check_model("t1");
    check("t1_counts_pound", pound_count, 2);
    check("t1_counts_p20", pence20_count, 3);

    // no pounds, only two 20p for 100p
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    mp = 0; mq = 0; mjp = 0; mjq = 0;
    load_p20(2);
    issue(100);
    wait_done(n);
    check_model("t2");
    check("t2_residual", residual, 60);
    check("t2_short", short_change, 1);

    // pound never sensed: jam, then 20p covers everything
    load_pounds(3);
    load_p20(7);
    pound_sense_en = 0;
    issue(140);
    wait_done(n);
    pound_sense_en = 1;
    check_model("t3");
    check("t3_jam_pound", jam_pound, 1);
    check("t3_residual", residual, 0);
    load_pounds(1);
    check_model("t3_cleared");

    // non-multiple of 20, then a zero refund
    load_p20(2);
    issue(50);
    wait_done(n);
    check("t4_residual", residual, 10);
    check("t4_short", short_change, 1);
    issue(0);
    wait_done(n);
    check("zero_done_latency", n, 0);
    check("zero_short", short_change, 0);
    check_model("t4");

    // second refund ignored; loads coinciding with drops cancel
    load_p20(4);
    load_on_sense = 1;
    issue(60);
    @(negedge clk);
    refund = 1;
    money = 12'd300;
    @(negedge clk);
    refund = 0;
    @(negedge clk);
    check("ignored_refund_ack", refund_ack, 0);
    wait_done(n);
    load_on_sense = 0;
    check_model("t5");

    // saturation
    load_p20(MAXC - mq);
    check("p20_at_max", pence20_count, MAXC);
    load_p20(1);
    check("p20_saturated", pence20_count, MAXC);

    // reset mid-FIRE
    issue(100);
    @(negedge clk);
    check("t6_firing", pound_out, 1);
    #2 reset_n = 0;
    #1 check_all_zero("midfire");
    exp_q.delete();
    done_q.delete();
    mp = 0; mq = 0; mjp = 0; mjq = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    load_pounds(1);
    issue(100);
    wait_done(n);
    check_model("t6");
    check("t6_residual", residual, 0);

    check("pulses_left", exp_q.size(), 0);
    check("dones_left", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
